// File: rtl/ccff_tail_readback.sv
// ccff_tail_readback: deserializes the config chain tail into FIFO-buffered words with a running CRC-16
module ccff_tail_readback #(
  parameter int BS_LGT = 8387,
  parameter int WORD_W = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int NW = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic [NW-1:0]     word_nbits,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       bit_count,
  output logic [15:0]       crc
);
  localparam int WI = $clog2(WORD_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LN = (BS_LGT % WORD_W == 0) ? WORD_W : BS_LGT % WORD_W;
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [WORD_W-1:0] sreg, word_nx, pq_data;
  logic [WI-1:0] widx;
  logic [15:0] crc_nx;
  logic go, sample, last_bit, word_end, pq, pq_last, pop, wr, full;
  logic [NW-1:0] pq_nbits;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
  logic mem_last [FIFO_DEPTH];
  logic [NW-1:0] mem_nbits [FIFO_DEPTH];
  assign go = start && (state == IDLE || state == DONE);
  assign sample = state == CAPTURE && shift_en;
  assign last_bit = bit_count == 32'(BS_LGT - 1);
  assign word_end = widx == WI'(WORD_W - 1);
  assign word_nx = sreg | (WORD_W'(ccff_tail) << widx);
  assign crc_nx = {crc[14:0], 1'b0} ^ ((crc[15] ^ ccff_tail) ? 16'h1021 : 16'h0000);
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign word_valid = cnt != '0;
  assign pop = word_valid && word_ready;
  assign wr = pq && (!full || pop);
  assign word_data = word_valid ? mem_data[rp] : '0;
  assign word_last = word_valid && mem_last[rp];
  assign word_nbits = word_valid ? mem_nbits[rp] : '0;
  assign busy = state == CAPTURE || state == FLUSH;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = go ? CAPTURE : state;
      CAPTURE:    state_nx = (sample && last_bit) ? FLUSH : CAPTURE;
      FLUSH:      state_nx = (word_valid || pq) ? FLUSH : DONE;
      default:    state_nx = IDLE;
    endcase
  end
  // Completed words pass through one staging register before entering the FIFO
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state <= IDLE;
      sreg <= '0;
      widx <= '0;
      bit_count <= '0;
      crc <= 16'hFFFF;
      overflow <= 1'b0;
      pq <= 1'b0;
      pq_data <= '0;
      pq_last <= 1'b0;
      pq_nbits <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        sreg <= '0;
        widx <= '0;
        bit_count <= '0;
        crc <= 16'hFFFF;
      end else if (sample) begin
        sreg <= (word_end || last_bit) ? '0 : word_nx;
        widx <= (word_end || last_bit) ? '0 : widx + WI'(1);
        bit_count <= bit_count + 32'd1;
        crc <= crc_nx;
      end
      overflow <= go ? 1'b0 : overflow | (pq && !wr);
      pq <= sample && (word_end || last_bit);
      pq_data <= word_nx;
      pq_last <= last_bit;
      pq_nbits <= last_bit ? NW'(LN) : NW'(WORD_W);
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge prog_clk) begin
    if (wr) begin
      mem_data[wp] <= pq_data;
      mem_last[wp] <= pq_last;
      mem_nbits[wp] <= pq_nbits;
    end
  end
endmodule
